regbus_arbiter: RTL and testbench
=================================

Name: regbus_arbiter

Overview:
- Shares one internal register-bus slave port between two requesters (M0, M1), e.g. an AXI4-lite front-end and a debug/JTAG bridge.
- The slave port uses the same pulse-req/pulse-ack convention as the generated register banks, with separate write and read strobes.
- Requesters are granted round-robin, one transaction at a time.
- A watchdog terminates transactions the slave never acknowledges and returns an error ack.

Parameters:
- ADDR_W, 3: byte-address width of the register bus.
- DATA_W, 32: data width.
- TIMEOUT, 255: maximum number of WAIT cycles without a slave ack before an error ack; range 1..65535.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- mN_wr_req  in  1  (N = 0,1) one-cycle write request pulse.
- mN_rd_req  in  1  one-cycle read request pulse.
- mN_addr  in  ADDR_W  address; sampled on req.
- mN_wdata  in  DATA_W  write data; sampled on wr_req.
- mN_wr_ack  out  1  one-cycle write completion pulse.
- mN_rd_ack  out  1  one-cycle read completion pulse.
- mN_rdata  out  DATA_W  read data; valid while rd_ack = 1.
- mN_err  out  1  qualifies the ack as a timeout; valid while ack = 1.
- s_wr_req  out  1  slave write pulse.
- s_rd_req  out  1  slave read pulse.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wr_ack  in  1  slave write ack.
- s_rd_ack  in  1  slave read ack.
- s_rdata  in  DATA_W  slave read data.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending flags cleared, round-robin pointer favours M0. Reset mid-transaction drops it silently: no ack is issued and a later slave ack is ignored.
- Capture: each req pulse sets a per-master pending flag (wr or rd) and latches addr/wdata.
  - A master issues at most one outstanding transaction.
  - A new pulse while that master's same-type flag is set overwrites addr/wdata. This is a protocol violation; no error is reported.
  - wr_req and rd_req in the same cycle set both flags. The write is served first; the read follows as a separate transaction.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any pending flag is set, select a master: the one not served last if both are pending, otherwise the only requester.
  - Load s_addr/s_wdata from the selected master's latches, clear its flag, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - s_wr_req or s_rd_req = 1.
  - A slave ack in this same cycle is accepted.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - The slave ack matching the issued type completes the transaction. An ack of the other type is ignored.
  - The counter increments every WAIT cycle. Reaching TIMEOUT completes with err = 1 and rdata = 0.
- Completion:
  - The next cycle gives a registered one-cycle mN_wr_ack/mN_rd_ack to the granted master. mN_rdata is registered s_rdata; mN_err is 1 only on timeout.
  - The round-robin pointer then records that master and the FSM returns to IDLE. A new grant can occur in the following cycle.
- Latency with slave ack in the ISSUE cycle:
  - req at cycle 0, pending at 1, slave req at 2, master ack at 3.
  - Minimum turnaround is 3 cycles; back-to-back grants are 4 cycles apart.
- s_addr/s_wdata hold their values from ISSUE until the next grant.
- Non-granted master outputs: ack, err and rdata stay 0.
- Boundary conditions:
  - A request arriving in its own master's completion cycle is captured normally.
  - A late slave ack arriving after a timeout, in IDLE, is ignored.
  - The timeout counter saturates and never wraps.

Decomposition:
- Shared package regbus_pkg:
  - FSM state enum (IDLE/ISSUE/WAIT).
  - Master-index type.
  - Op type (WR/RD).
  - Error read-data constant (all zeros).
- One natural sub-module, regbus_req_latch, instantiated per master: holds the pending flags and addr/wdata latches, and provides a clear-on-grant input.

Test Plan:
- Single write: M0 write addr 0x4, data 0x12345678; slave acks in the ISSUE cycle -> s_wr_req at cycle 2 with s_wdata = 0x12345678, m0_wr_ack at cycle 3, m0_err = 0.
- Simultaneous reads: M0 and M1 issue rd_req in the same cycle; slave returns 0xA5A5A5A5 then 0x5A5A5A5A -> M0 is served first, M1 next; each master gets its own data and the acks are 4 cycles apart.
- Fairness: M0 requests continuously and M1 requests once -> M1 is granted at the next arbitration after M0's current transaction; grants alternate M0, M1, M0.
- Timeout: TIMEOUT = 4 and the slave never acks -> m0_rd_ack with m0_err = 1 and rdata = 0 after 4 WAIT cycles; a late s_rd_ack 2 cycles later is ignored.
- Same-cycle wr + rd: M1 issues both strobes -> a write transaction completes with wr_ack, then a read with rd_ack; 2 slave transactions in that order.
- Reset mid-WAIT: assert areset for 1 cycle while WAIT is active -> no master ack, all outputs 0, and the next M1 request completes normally.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and constants for the two-master register-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regbus_pkg;

    // Arbiter sequencing: pick a requester, pulse the slave, wait for its ack.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Requester index.
    typedef logic [0:0] mst_t;
    localparam mst_t M0 = 1'b0;
    localparam mst_t M1 = 1'b1;

    // Transaction type of the granted request.
    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

    // Read data returned with a timeout error ack; wide enough for DATA_W up to 64.
    localparam logic [63:0] ERR_RDATA = '0;

    // Width of the watchdog counter; TIMEOUT is limited to 1..65535.
    localparam int CNT_W = 16;

endpackage

// File: rtl/regbus_if.sv
// Pulse-req/pulse-ack register-bus port with separate write and read strobes.
// Latency: n/a (wiring only).
// Backpressure: none; a request is held off only by withholding the ack.
interface regbus_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_ack;
    logic              rd_ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    // Issuing side. err is only produced by the arbiter toward its requesters,
    // so the arbiter's own downstream port does not consume it.
    modport master (
        output wr_req, rd_req, addr, wdata,
        input  wr_ack, rd_ack, rdata
    );

    // Responding side.
    modport slave (
        input  wr_req, rd_req, addr, wdata,
        output wr_ack, rd_ack, rdata, err
    );
endinterface

// File: rtl/regbus_req_latch.sv
// Per-master capture of request pulses into pending flags plus addr/wdata latches.
// Latency: a req pulse is visible as pending one cycle later.
// Backpressure: none; a new pulse on a pending flag overwrites the latched fields.
module regbus_req_latch #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_wr,
    input  logic              clr_rd,
    output logic              wr_pend,
    output logic              rd_pend,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] wdata_q
);

    // Pending flags: a fresh pulse wins over a same-cycle clear-on-grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            if (wr_req)
                wr_pend <= 1'b1;
            else if (clr_wr)
                wr_pend <= 1'b0;
            if (rd_req)
                rd_pend <= 1'b1;
            else if (clr_rd)
                rd_pend <= 1'b0;
        end
    end

    // Address is shared by a same-cycle wr+rd pair; wdata only follows writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (wr_req || rd_req)
                addr_q <= addr;
            if (wr_req)
                wdata_q <= wdata;
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin share of one register-bus slave between two requesters, with watchdog.
// Latency: req -> master ack in 3 cycles when the slave acks in the issue cycle.
// Backpressure: one transaction at a time; a silent slave is cut off after TIMEOUT cycles.
module regbus_arbiter
    import regbus_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic     aclk,
    input  logic     areset,
    regbus_if.slave  m0,
    regbus_if.slave  m1,
    regbus_if.master s
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic [1:0]        wr_pend;
    logic [1:0]        rd_pend;
    logic [ADDR_W-1:0] addr_q  [2];
    logic [DATA_W-1:0] wdata_q [2];
    logic [1:0]        clr_wr;
    logic [1:0]        clr_rd;

    state_t            state;
    mst_t              gnt;
    mst_t              rr_last;
    op_t               op;
    logic              cmpl;
    logic              hold;
    logic [CNT_W-1:0]  cnt;

    mst_t              sel;
    logic              sel_wr;
    logic              grant;
    logic              hit;
    logic              tmo;
    logic              fin;
    logic [CNT_W-1:0]  cnt_inc;

    regbus_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lat0 (
        .clk     (aclk),
        .rst     (areset),
        .wr_req  (m0.wr_req),
        .rd_req  (m0.rd_req),
        .addr    (m0.addr),
        .wdata   (m0.wdata),
        .clr_wr  (clr_wr[0]),
        .clr_rd  (clr_rd[0]),
        .wr_pend (wr_pend[0]),
        .rd_pend (rd_pend[0]),
        .addr_q  (addr_q[0]),
        .wdata_q (wdata_q[0])
    );

    regbus_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lat1 (
        .clk     (aclk),
        .rst     (areset),
        .wr_req  (m1.wr_req),
        .rd_req  (m1.rd_req),
        .addr    (m1.addr),
        .wdata   (m1.wdata),
        .clr_wr  (clr_wr[1]),
        .clr_rd  (clr_rd[1]),
        .wr_pend (wr_pend[1]),
        .rd_pend (rd_pend[1]),
        .addr_q  (addr_q[1]),
        .wdata_q (wdata_q[1])
    );

    // Arbitration: with both pending the master not served last wins; writes go before reads.
    always_comb begin
        logic [1:0] any;
        any = wr_pend | rd_pend;
        if (any == 2'b11)
            sel = (rr_last == M0) ? M1 : M0;
        else if (any[1])
            sel = M1;
        else
            sel = M0;
        sel_wr    = wr_pend[sel];
        grant     = (state == ST_IDLE) && !hold && (any != 2'b00);
        clr_wr[0] = grant && (sel == M0) && sel_wr;
        clr_rd[0] = grant && (sel == M0) && !sel_wr;
        clr_wr[1] = grant && (sel == M1) && sel_wr;
        clr_rd[1] = grant && (sel == M1) && !sel_wr;
    end

    // Completion detect: matching slave ack, or the watchdog reaching TIMEOUT (saturating).
    always_comb begin
        hit     = (op == OP_WR) ? s.wr_ack : s.rd_ack;
        cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        tmo     = (state == ST_WAIT) && !cmpl && !hit && (cnt_inc >= TMO);
        fin     = (!cmpl && hit && ((state == ST_ISSUE) || (state == ST_WAIT))) || tmo;
    end

    // Sequencer: grant, one-cycle slave strobe, wait, then one completion cycle and one idle gap.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= ST_IDLE;
            gnt      <= M0;
            rr_last  <= M1;
            op       <= OP_WR;
            cmpl     <= 1'b0;
            hold     <= 1'b0;
            cnt      <= '0;
            s.wr_req <= 1'b0;
            s.rd_req <= 1'b0;
            s.addr   <= '0;
            s.wdata  <= '0;
        end else begin
            s.wr_req <= 1'b0;
            s.rd_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hold <= 1'b0;
                    if (grant) begin
                        gnt      <= sel;
                        op       <= sel_wr ? OP_WR : OP_RD;
                        s.addr   <= addr_q[sel];
                        s.wdata  <= wdata_q[sel];
                        s.wr_req <= sel_wr;
                        s.rd_req <= !sel_wr;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    cmpl  <= fin;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmpl) begin
                        cmpl    <= 1'b0;
                        rr_last <= gnt;
                        hold    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cmpl <= fin;
                        cnt  <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered responses; the non-granted master sees all zeros.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m0.wr_ack <= 1'b0;
            m0.rd_ack <= 1'b0;
            m0.err    <= 1'b0;
            m0.rdata  <= '0;
            m1.wr_ack <= 1'b0;
            m1.rd_ack <= 1'b0;
            m1.err    <= 1'b0;
            m1.rdata  <= '0;
        end else begin
            m0.wr_ack <= fin && (gnt == M0) && (op == OP_WR);
            m0.rd_ack <= fin && (gnt == M0) && (op == OP_RD);
            m0.err    <= fin && (gnt == M0) && tmo;
            m0.rdata  <= (fin && (gnt == M0) && (op == OP_RD))
                         ? (tmo ? ERR_RDATA[DATA_W-1:0] : s.rdata) : '0;
            m1.wr_ack <= fin && (gnt == M1) && (op == OP_WR);
            m1.rd_ack <= fin && (gnt == M1) && (op == OP_RD);
            m1.err    <= fin && (gnt == M1) && tmo;
            m1.rdata  <= (fin && (gnt == M1) && (op == OP_RD))
                         ? (tmo ? ERR_RDATA[DATA_W-1:0] : s.rdata) : '0;
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: per-cycle vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: slave model acks combinationally or stays silent on demand.
module tb_regbus_arbiter;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    regbus_if #(.ADDR_W(3), .DATA_W(32)) m0_if ();
    regbus_if #(.ADDR_W(3), .DATA_W(32)) m1_if ();
    regbus_if #(.ADDR_W(3), .DATA_W(32)) s_if ();

    regbus_arbiter #(.ADDR_W(3), .DATA_W(32), .TIMEOUT(4)) dut (
        .aclk   (aclk),
        .areset (areset),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
    );

    // Slave model: optional same-cycle ack plus forced stray acks.
    logic        auto_ack, f_wr_ack, f_rd_ack;
    logic [31:0] srdata;
    always_comb begin
        s_if.wr_ack = (auto_ack & s_if.wr_req) | f_wr_ack;
        s_if.rd_ack = (auto_ack & s_if.rd_req) | f_rd_ack;
        s_if.rdata  = srdata;
        s_if.err    = 1'b0;
    end

    int cyc = 0;
    int base = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int          cyc;
        bit          mst;
        bit          rd;
        bit          err;
        logic [31:0] rdata;
    } ack_t;
    typedef struct {
        bit          rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } stx_t;
    ack_t acks[$];
    stx_t stx[$];

    // Log every master ack and every slave strobe with its cycle relative to the sequence start.
    always @(posedge aclk) begin
        if (m0_if.wr_ack || m0_if.rd_ack)
            acks.push_back('{cyc - base, 1'b0, m0_if.rd_ack, m0_if.err, m0_if.rdata});
        if (m1_if.wr_ack || m1_if.rd_ack)
            acks.push_back('{cyc - base, 1'b1, m1_if.rd_ack, m1_if.err, m1_if.rdata});
        if (s_if.wr_req || s_if.rd_req)
            stx.push_back('{s_if.rd_req, s_if.addr, s_if.wdata});
    end

    typedef struct packed {
        logic        swr, srd;
        logic [2:0]  saddr;
        logic [31:0] swdata;
        logic        m0wa, m0ra, m0err;
        logic [31:0] m0rd;
        logic        m1wa, m1ra, m1err;
        logic [31:0] m1rd;
    } obs_t;

    typedef struct {
        logic [3:0]  req;     // {m0_wr, m0_rd, m1_wr, m1_rd}
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] srdata;
        obs_t        exp;
    } vec_t;

    function automatic obs_t sample();
        obs_t o;
        o.swr = s_if.wr_req;     o.srd = s_if.rd_req;
        o.saddr = s_if.addr;     o.swdata = s_if.wdata;
        o.m0wa = m0_if.wr_ack;   o.m0ra = m0_if.rd_ack;
        o.m0err = m0_if.err;     o.m0rd = m0_if.rdata;
        o.m1wa = m1_if.wr_ack;   o.m1ra = m1_if.rd_ack;
        o.m1err = m1_if.err;     o.m1rd = m1_if.rdata;
        return o;
    endfunction

    function automatic vec_t mkv(input logic [3:0] req, input logic [2:0] a,
                                 input logic [31:0] wd, input logic [31:0] sd,
                                 input logic [1:0] sreq, input logic [2:0] sa,
                                 input logic [31:0] swd, input logic [3:0] ack,
                                 input logic [1:0] er, input logic [31:0] r0,
                                 input logic [31:0] r1);
        vec_t v;
        v.req = req; v.addr = a; v.wdata = wd; v.srdata = sd;
        v.exp.swr = sreq[1];  v.exp.srd = sreq[0];
        v.exp.saddr = sa;     v.exp.swdata = swd;
        v.exp.m0wa = ack[3];  v.exp.m0ra = ack[2]; v.exp.m0err = er[1]; v.exp.m0rd = r0;
        v.exp.m1wa = ack[1];  v.exp.m1ra = ack[0]; v.exp.m1err = er[0]; v.exp.m1rd = r1;
        return v;
    endfunction

    function automatic logic [127:0] pk_ack(input ack_t a);
        return {32'(a.cyc), 4'(a.mst), 4'(a.rd), 4'(a.err), a.rdata};
    endfunction

    function automatic logic [127:0] pk_stx(input stx_t t);
        return {4'(t.rd), 5'(t.addr), t.wdata};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic chk_ack(input string nm, input int k, input ack_t e);
        logic [127:0] act;
        act = (k < acks.size()) ? pk_ack(acks[k]) : '1;
        chk(nm, act, pk_ack(e));
    endtask

    task automatic chk_stx(input string nm, input int k, input stx_t e);
        logic [127:0] act;
        act = (k < stx.size()) ? pk_stx(stx[k]) : '1;
        chk(nm, act, pk_stx(e));
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        m0_if.wr_req = 0; m0_if.rd_req = 0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.wr_req = 0; m1_if.rd_req = 0; m1_if.addr = '0; m1_if.wdata = '0;
        auto_ack = 1'b1; f_wr_ack = 1'b0; f_rd_ack = 1'b0; srdata = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_inputs();
        step();
        step();
        areset = 1'b0;
        acks.delete();
        stx.delete();
        base = cyc;
    endtask

    vec_t tbl[13];

    initial begin
        // Cycles 0-7: simultaneous reads (M0 first, acks 4 apart); 8-12: single M0 write.
        tbl[0]  = mkv(4'b0101, 3'd2, 32'h0, 32'h0,        2'b00, 3'd0, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[1]  = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd0, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[2]  = mkv(4'b0000, 3'd0, 32'h0, 32'hA5A5A5A5, 2'b01, 3'd2, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[3]  = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd2, 32'h0,        4'b0100, 2'b00, 32'hA5A5A5A5, 32'h0);
        tbl[4]  = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd2, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[5]  = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd2, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[6]  = mkv(4'b0000, 3'd0, 32'h0, 32'h5A5A5A5A, 2'b01, 3'd2, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[7]  = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd2, 32'h0,        4'b0001, 2'b00, 32'h0,        32'h5A5A5A5A);
        tbl[8]  = mkv(4'b1000, 3'd4, 32'h12345678, 32'h0, 2'b00, 3'd2, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[9]  = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd2, 32'h0,        4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[10] = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b10, 3'd4, 32'h12345678, 4'b0000, 2'b00, 32'h0,        32'h0);
        tbl[11] = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd4, 32'h12345678, 4'b1000, 2'b00, 32'h0,        32'h0);
        tbl[12] = mkv(4'b0000, 3'd0, 32'h0, 32'h0,        2'b00, 3'd4, 32'h12345678, 4'b0000, 2'b00, 32'h0,        32'h0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("vec%0d", i), 128'(sample()), 128'(tbl[i].exp));
            {m0_if.wr_req, m0_if.rd_req, m1_if.wr_req, m1_if.rd_req} = tbl[i].req;
            m0_if.addr = tbl[i].addr;  m1_if.addr = tbl[i].addr;
            m0_if.wdata = tbl[i].wdata; m1_if.wdata = tbl[i].wdata;
            srdata = tbl[i].srdata;
            step();
        end
        clear_inputs();

        // Fairness: M0 re-requests in each of its own completion cycles, M1 requests once.
        do_reset();
        m0_if.addr = 3'd1;
        m1_if.addr = 3'd3;
        for (int r = 0; r < 16; r++) begin
            m0_if.rd_req = (r == 0) || m0_if.rd_ack;
            m1_if.rd_req = (r == 1);
            step();
        end
        clear_inputs();
        chk("fair_count", 128'(acks.size()), 128'(4));
        chk_ack("fair_0", 0, '{3,  1'b0, 1'b1, 1'b0, 32'h0});
        chk_ack("fair_1", 1, '{7,  1'b1, 1'b1, 1'b0, 32'h0});
        chk_ack("fair_2", 2, '{11, 1'b0, 1'b1, 1'b0, 32'h0});
        chk_ack("fair_3", 3, '{15, 1'b0, 1'b1, 1'b0, 32'h0});

        // Timeout after 4 silent WAIT cycles, stray late ack ignored, then a normal M1 read.
        do_reset();
        srdata = 32'hFFFFFFFF;
        m0_if.addr = 3'd5;
        m1_if.addr = 3'd7;
        for (int r = 0; r < 16; r++) begin
            m0_if.rd_req = (r == 0);
            m1_if.rd_req = (r == 11);
            f_rd_ack = (r == 9);
            auto_ack = (r >= 11);
            step();
        end
        clear_inputs();
        chk("tmo_count", 128'(acks.size()), 128'(2));
        chk_ack("tmo_err_ack", 0, '{7,  1'b0, 1'b1, 1'b1, 32'h0});
        chk_ack("tmo_next_m1", 1, '{14, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF});
        chk("tmo_slave_txns", 128'(stx.size()), 128'(2));

        // Same-cycle write and read from M1: write transaction first, then the read.
        do_reset();
        srdata = 32'h0BADF00D;
        for (int r = 0; r < 12; r++) begin
            m1_if.wr_req = (r == 0);
            m1_if.rd_req = (r == 0);
            m1_if.addr   = 3'd6;
            m1_if.wdata  = 32'hDEADBEEF;
            step();
        end
        clear_inputs();
        chk("wrrd_txn_count", 128'(stx.size()), 128'(2));
        chk_stx("wrrd_txn_wr", 0, '{1'b0, 3'd6, 32'hDEADBEEF});
        chk_stx("wrrd_txn_rd", 1, '{1'b1, 3'd6, 32'hDEADBEEF});
        chk_ack("wrrd_wr_ack", 0, '{3, 1'b1, 1'b0, 1'b0, 32'h0});
        chk_ack("wrrd_rd_ack", 1, '{7, 1'b1, 1'b1, 1'b0, 32'h0BADF00D});

        // Reset during WAIT drops the write; stray ack ignored; next M1 read completes.
        do_reset();
        auto_ack = 1'b0;
        for (int r = 0; r < 14; r++) begin
            if (r == 5)
                chk("rst_outputs_zero", 128'(sample()), 128'(0));
            m0_if.wr_req = (r == 0);
            m0_if.addr   = 3'd3;
            m0_if.wdata  = 32'h11112222;
            areset       = (r == 4);
            f_wr_ack     = (r == 6);
            m1_if.rd_req = (r == 7);
            m1_if.addr   = 3'd1;
            if (r == 7) begin
                auto_ack = 1'b1;
                srdata   = 32'h00000077;
            end
            step();
        end
        clear_inputs();
        chk("rst_ack_count", 128'(acks.size()), 128'(1));
        chk_ack("rst_m1_ack", 0, '{10, 1'b1, 1'b1, 1'b0, 32'h00000077});
        chk_stx("rst_m1_txn", 1, '{1'b1, 3'd1, 32'h0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
